// File: rtl/mode_sequencer_pkg.sv
// Shared constants for the front-panel mode sequencer: mode encoding, button
// indices into btn_i ({U,C,L,R,D}) and default bus/idle sizes.
package mode_sequencer_pkg;

   localparam int DEF_DATA_W      = 36;
   localparam int DEF_IDLE_CYCLES = 30000;
   localparam int NUM_BTNS        = 5;

   localparam int BTN_D = 0;
   localparam int BTN_R = 1;
   localparam int BTN_L = 2;
   localparam int BTN_C = 3;
   localparam int BTN_U = 4;

   typedef enum logic [1:0] {
      MODE_CLOCK = 2'd0,
      MODE_SW    = 2'd1,
      MODE_TIMER = 2'd2,
      MODE_BAD   = 2'd3
   } mode_e;

   // Successor in the CLOCK -> SW -> TIMER ring; anything else recovers to CLOCK.
   function automatic mode_e next_mode(input mode_e m);
      case (m)
         MODE_CLOCK: return MODE_SW;
         MODE_SW:    return MODE_TIMER;
         default:    return MODE_CLOCK;
      endcase
   endfunction

endpackage

// File: rtl/mode_sequencer_btn_edge.sv
// Vectored rising-edge detector. History resets to all-ones so a button held
// through reset release must be released and pressed again to register.
module btn_edge #(
   parameter int WIDTH = 5
) (
   input  logic             clk_i,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] level_i,
   output logic [WIDTH-1:0] press_o
);

   logic [WIDTH-1:0] hist;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         hist    <= '1;
         press_o <= '0;
      end else begin
         hist    <= level_i;
         press_o <= level_i & ~hist;
      end
   end

endmodule

// File: rtl/mode_sequencer.sv
// Front-panel mode owner: steps CLOCK -> SW -> TIMER on U and gates button
// pulses to the owning block. Optional idle auto-return under AUTO_RETURN_EN.
module mode_sequencer
   import mode_sequencer_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
   input  logic              clk_i,
   input  logic              reset_n,
   input  logic [4:0]        btn_i,
   input  logic              clk_edit_i,
   input  logic [DATA_W-1:0] clk_cnt_i,
   input  logic [DATA_W-1:0] sw_cnt_i,
   input  logic [DATA_W-1:0] tmr_cnt_i,
   output logic [1:0]        mode_o,
   output logic [3:0]        clk_btn_o,
   output logic              sw_start_o,
   output logic              sw_stop_o,
   output logic              sw_resetn_o,
   output logic [3:0]        tmr_btn_o,
   output logic [DATA_W-1:0] disp_cnt_o,
   output logic              disp_edit_o
);

   logic [NUM_BTNS-1:0] press;
   mode_e               state, state_nxt;
   logic                idle_exp;

   btn_edge #(.WIDTH(NUM_BTNS)) u_btn_edge (
      .clk_i   (clk_i),
      .reset_n (reset_n),
      .level_i (btn_i),
      .press_o (press)
   );

`ifdef AUTO_RETURN_EN
   localparam int IDLE_W = ($clog2(IDLE_CYCLES) < 1) ? 1 : $clog2(IDLE_CYCLES);

   logic [IDLE_W-1:0] idle_cnt;

   assign idle_exp = (idle_cnt == IDLE_W'(IDLE_CYCLES - 1));

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n)
         idle_cnt <= '0;
      else if ((|press) || (state == MODE_CLOCK) || idle_exp)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + IDLE_W'(1);
   end
`else
   assign idle_exp = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n)
         state <= MODE_CLOCK;
      else
         state <= state_nxt;
   end

   // Press pulses are already registered, so routing is a pure gate on the
   // mode that was current when the press was sampled.
   always_comb begin
      state_nxt   = state;
      clk_btn_o   = '0;
      tmr_btn_o   = '0;
      sw_start_o  = 1'b0;
      sw_stop_o   = 1'b0;
      sw_resetn_o = 1'b1;

      case (state)
         MODE_CLOCK: begin
            clk_btn_o = press[BTN_C:BTN_D];
            if (press[BTN_U] && !clk_edit_i)
               state_nxt = next_mode(state);
         end
         MODE_SW: begin
            sw_start_o  = press[BTN_L];
            sw_stop_o   = press[BTN_R];
            sw_resetn_o = ~press[BTN_D];
            if (press[BTN_U])
               state_nxt = next_mode(state);
         end
         MODE_TIMER: begin
            tmr_btn_o = press[BTN_C:BTN_D];
            if (press[BTN_U])
               state_nxt = next_mode(state);
         end
         default: state_nxt = MODE_CLOCK;
      endcase

      // Any press on the expiry edge takes precedence over auto-return.
      if (idle_exp && (press == '0))
         state_nxt = MODE_CLOCK;
   end

   assign mode_o = state;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         disp_cnt_o  <= '0;
         disp_edit_o <= 1'b0;
      end else begin
         case (state)
            MODE_CLOCK: disp_cnt_o <= clk_cnt_i;
            MODE_SW:    disp_cnt_o <= sw_cnt_i;
            MODE_TIMER: disp_cnt_o <= tmr_cnt_i;
            default:    disp_cnt_o <= '0;
         endcase
         disp_edit_o <= (state == MODE_CLOCK) && clk_edit_i;
      end
   end

endmodule
